mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter: MAX_D_STREAK, default 4, maximum consecutive data grants while fetch waits.
REQ-002 Parameter: TIMEOUT, default 255, maximum cycles waiting on mem_ready before abort.
REQ-003 Ports: clk input 1, sole clock; all state on rising edge.
REQ-004 Ports: reset input 1, asynchronous, active-low (0 = reset).
REQ-005 Ports: if_req input 1 fetch read request; if_addr input 32 fetch address (PCF).
REQ-006 Ports: dm_req input 1 data request; dm_we input 1 write; dm_addr input 32; dm_wdata input 32; dm_be input 4 byte enables.
REQ-007 Ports: mem_req output 1; mem_we output 1; mem_addr output 32; mem_wdata output 32; mem_be output 4 (shared memory port).
REQ-008 Ports: mem_ready input 1 access complete; mem_rdata input 32 read data, valid with mem_ready.
REQ-009 Ports: if_done output 1; if_rdata output 32; dm_done output 1; dm_rdata output 32; err output 1 timeout pulse.
REQ-010 Ports: stall_f output 1 fetch stall; stall_m output 1 memory-stage stall.

Function
REQ-011 FSM states IDLE, GRANT_I, GRANT_D; reset state IDLE.
REQ-012 IDLE, dm_req=1, not (if_req=1 and streak=MAX_D_STREAK) -> GRANT_D; latch dm_addr/dm_we/dm_wdata/dm_be.
REQ-013 IDLE, if_req=1 and (dm_req=0 or streak=MAX_D_STREAK) -> GRANT_I; latch if_addr, mem_we=0, mem_be=4'hF.
REQ-014 mem_req, mem_we, mem_addr, mem_wdata, mem_be registered; mem_req=1 exactly while state is GRANT_I or GRANT_D.
REQ-015 GRANT_x with mem_ready=1 -> IDLE; capture mem_rdata into if_rdata or dm_rdata; pulse if_done or dm_done for the next cycle only.
REQ-016 Minimum latency: request sampled at edge N, mem_req high N+1, done high N+2 when mem_ready=1 during cycle N+1.
REQ-017 No new grant issued in the cycle a done pulse is high; next arbitration happens that cycle's edge, preventing re-grant of the completing request.
REQ-018 streak: 3-bit saturating count of consecutive data grants; cleared on fetch grant or when if_req=0 at a data grant; saturates at MAX_D_STREAK.
REQ-019 Timeout counter 8 bits, cleared on entry to GRANT_x, increments each cycle without mem_ready; reaching TIMEOUT -> IDLE, err pulses 1 cycle, done pulses, rdata=32'hDEADBEEF.
REQ-020 stall_f = if_req and not if_done (combinational); stall_m = dm_req and not dm_done (combinational).
REQ-021 Requester inputs ignored outside IDLE; requester holds req and operands stable until its done pulse.
REQ-022 if_rdata and dm_rdata hold last captured value until next capture.
REQ-023 mem_ready while in IDLE is ignored.

Reset
REQ-024 reset=0: state IDLE; mem_req, mem_we, if_done, dm_done, err = 0; mem_addr, mem_wdata, if_rdata, dm_rdata = 0; mem_be = 0; streak, timeout = 0.
REQ-025 Reset asserted mid-access aborts immediately; no done pulse; first grant occurs no earlier than the second edge after release.

Structure
REQ-026 Package mem_arb_pkg holds the state enum (IDLE, GRANT_I, GRANT_D), MAX_D_STREAK and TIMEOUT defaults, and the 32'hDEADBEEF error word.
REQ-027 Single flat module, no sub-modules; the FSM, streak counter and timeout counter share one always_ff block set.

Verification
REQ-028 Fetch only: if_req=1, if_addr=0x100, mem_ready after 1 cycle, rdata=0xE3A00001 -> mem_req at N+1, if_done at N+2, if_rdata=0xE3A00001.
REQ-029 Simultaneous: if_req=1, dm_req=1 (write 0x200, wdata=0x55, be=4'b0001), streak=0 -> data granted first (mem_we=1, mem_be=0001), then fetch; stall_f high throughout.
REQ-030 Starvation: dm_req continuously re-asserted and if_req=1 -> after 4 data grants the 5th grant is fetch.
REQ-031 Timeout: dm_req read, mem_ready held 0 -> after 255 cycles err=1 and dm_done=1 in the same cycle, dm_rdata=0xDEADBEEF, state IDLE.
REQ-032 Reset mid-access: reset=0 during GRANT_D -> mem_req=0 asynchronously, no dm_done; after release, pending dm_req regranted.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the memory port arbiter
//
// Contents:
//   arb_state_t      : arbiter FSM states (IDLE, GRANT_I, GRANT_D)
//   MAX_D_STREAK_DEF : default cap on back-to-back data grants while fetch waits
//   TIMEOUT_DEF      : default number of unanswered cycles before an access aborts
//   ERR_WORD         : read data returned to the requester on an aborted access
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2
    } arb_state_t;

    localparam int          MAX_D_STREAK_DEF = 4;
    localparam int          TIMEOUT_DEF      = 255;
    localparam logic [31:0] ERR_WORD         = 32'hDEADBEEF;

endpackage

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one memory port between instruction fetch and data access
//
// Ports:
//   clk, reset                         : clock, asynchronous active-low reset
//   if_req, if_addr                    : fetch read request and address
//   dm_req, dm_we, dm_addr,
//   dm_wdata, dm_be                    : data request, write flag, address, write data, byte enables
//   mem_req, mem_we, mem_addr,
//   mem_wdata, mem_be                  : registered shared memory port command
//   mem_ready, mem_rdata               : memory completion and read data
//   if_done, if_rdata                  : fetch completion pulse and captured read data
//   dm_done, dm_rdata                  : data completion pulse and captured read data
//   err                                : one-cycle pulse when an access times out
//   stall_f, stall_m                   : requester stalls (request pending, not yet done)
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MAX_D_STREAK = MAX_D_STREAK_DEF,
    parameter int TIMEOUT      = TIMEOUT_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    input  logic [3:0]  dm_be,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        if_done,
    output logic [31:0] if_rdata,
    output logic        dm_done,
    output logic [31:0] dm_rdata,
    output logic        err,
    output logic        stall_f,
    output logic        stall_m
);

    localparam logic [2:0] STREAK_MAX = 3'(MAX_D_STREAK);
    localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT);

    arb_state_t  state, state_n;
    logic        mem_req_n, mem_we_n;
    logic [31:0] mem_addr_n, mem_wdata_n;
    logic [3:0]  mem_be_n;
    logic        if_done_n, dm_done_n, err_n;
    logic [31:0] if_rdata_n, dm_rdata_n;
    logic [2:0]  streak, streak_n;
    logic [7:0]  tcnt, tcnt_n, tcnt_inc;
    // Held low through the first edge after reset release so that the
    // earliest grant lands on the second edge.
    logic        arb_en, arb_en_n;
    logic        streak_sat;

    assign streak_sat = (streak == STREAK_MAX);
    assign tcnt_inc   = tcnt + 8'd1;

    always_comb begin
        state_n     = state;
        mem_req_n   = mem_req;
        mem_we_n    = mem_we;
        mem_addr_n  = mem_addr;
        mem_wdata_n = mem_wdata;
        mem_be_n    = mem_be;
        if_done_n   = 1'b0;
        dm_done_n   = 1'b0;
        err_n       = 1'b0;
        if_rdata_n  = if_rdata;
        dm_rdata_n  = dm_rdata;
        streak_n    = streak;
        tcnt_n      = tcnt;
        arb_en_n    = 1'b1;

        case (state)
            IDLE: begin
                // While a done pulse is out, the finishing requester still
                // presents its old request; skip arbitration for that edge.
                if (arb_en && !if_done && !dm_done) begin
                    if (dm_req && !(if_req && streak_sat)) begin
                        state_n     = GRANT_D;
                        mem_req_n   = 1'b1;
                        mem_we_n    = dm_we;
                        mem_addr_n  = dm_addr;
                        mem_wdata_n = dm_wdata;
                        mem_be_n    = dm_be;
                        tcnt_n      = 8'd0;
                        // Only count streaks that actually keep fetch waiting.
                        streak_n    = if_req ? streak + 3'd1 : 3'd0;
                    end else if (if_req) begin
                        state_n    = GRANT_I;
                        mem_req_n  = 1'b1;
                        mem_we_n   = 1'b0;
                        mem_addr_n = if_addr;
                        mem_be_n   = 4'hF;
                        tcnt_n     = 8'd0;
                        streak_n   = 3'd0;
                    end
                end
            end
            GRANT_I, GRANT_D: begin
                if (mem_ready) begin
                    state_n   = IDLE;
                    mem_req_n = 1'b0;
                    if (state == GRANT_I) begin
                        if_done_n  = 1'b1;
                        if_rdata_n = mem_rdata;
                    end else begin
                        dm_done_n  = 1'b1;
                        dm_rdata_n = mem_rdata;
                    end
                end else begin
                    tcnt_n = tcnt_inc;
                    if (tcnt_inc == TIMEOUT_LIM) begin
                        state_n   = IDLE;
                        mem_req_n = 1'b0;
                        err_n     = 1'b1;
                        if (state == GRANT_I) begin
                            if_done_n  = 1'b1;
                            if_rdata_n = ERR_WORD;
                        end else begin
                            dm_done_n  = 1'b1;
                            dm_rdata_n = ERR_WORD;
                        end
                    end
                end
            end
            default: begin
                state_n   = IDLE;
                mem_req_n = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'd0;
            mem_wdata <= 32'd0;
            mem_be    <= 4'd0;
            if_done   <= 1'b0;
            dm_done   <= 1'b0;
            err       <= 1'b0;
            if_rdata  <= 32'd0;
            dm_rdata  <= 32'd0;
            streak    <= 3'd0;
            tcnt      <= 8'd0;
            arb_en    <= 1'b0;
        end else begin
            state     <= state_n;
            mem_req   <= mem_req_n;
            mem_we    <= mem_we_n;
            mem_addr  <= mem_addr_n;
            mem_wdata <= mem_wdata_n;
            mem_be    <= mem_be_n;
            if_done   <= if_done_n;
            dm_done   <= dm_done_n;
            err       <= err_n;
            if_rdata  <= if_rdata_n;
            dm_rdata  <= dm_rdata_n;
            streak    <= streak_n;
            tcnt      <= tcnt_n;
            arb_en    <= arb_en_n;
        end
    end

    assign stall_f = if_req & ~if_done;
    assign stall_m = dm_req & ~dm_done;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter
module tb_mem_port_arbiter;

    localparam int TB_TIMEOUT = 255;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        bit          chk_wdata;
    } grant_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic        dm_req, dm_we;
    logic [31:0] dm_addr, dm_wdata;
    logic [3:0]  dm_be;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        if_done, dm_done, err, stall_f, stall_m;
    logic [31:0] if_rdata, dm_rdata;

    always #5 clk = ~clk;

    mem_port_arbiter #(.MAX_D_STREAK(4), .TIMEOUT(TB_TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_be(dm_be),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .if_done(if_done), .if_rdata(if_rdata), .dm_done(dm_done), .dm_rdata(dm_rdata),
        .err(err), .stall_f(stall_f), .stall_m(stall_m)
    );

    int          checks = 0;
    int          errors = 0;
    grant_t      gq[$];
    logic [31:0] iq[$];
    logic [31:0] dq[$];
    logic [31:0] mq[$];
    int          mem_lat = 0;
    int          busy = 0;
    bit          ready_in_idle = 0;
    logic        prev_req = 1'b0;
    bit          saw_if = 0, saw_dm = 0, saw_err = 0;
    logic [31:0] last_if = 32'd0;

    function automatic grant_t mk_g(input logic we, input logic [31:0] addr,
                                    input logic [31:0] wdata, input logic [3:0] be,
                                    input bit chk_wdata);
        grant_t g;
        g.we = we; g.addr = addr; g.wdata = wdata; g.be = be; g.chk_wdata = chk_wdata;
        return g;
    endfunction

    // One clock: observe grants and done pulses against the scoreboard, then
    // play the memory for the coming cycle.
    task automatic sb_cycle();
        grant_t      g;
        logic [31:0] e;
        @(posedge clk);
        #1;
        saw_if  = if_done;
        saw_dm  = dm_done;
        saw_err = err;
        if (mem_req && !prev_req) begin
            busy = 0;
            checks++;
            if (gq.size() == 0) begin
                errors++;
                $display("FAIL grant_unexpected: got addr=%h we=%b, required no grant", mem_addr, mem_we);
            end else begin
                g = gq.pop_front();
                if (mem_we !== g.we || mem_addr !== g.addr || mem_be !== g.be ||
                    (g.chk_wdata && mem_wdata !== g.wdata)) begin
                    errors++;
                    $display("FAIL grant_fields: got we=%b addr=%h wdata=%h be=%h, required we=%b addr=%h wdata=%h be=%h",
                             mem_we, mem_addr, mem_wdata, mem_be, g.we, g.addr, g.wdata, g.be);
                end
            end
        end
        prev_req = mem_req;
        if (if_done) begin
            checks++;
            if (iq.size() == 0) begin
                errors++;
                $display("FAIL if_done_unexpected: got if_rdata=%h, required no done", if_rdata);
            end else begin
                e = iq.pop_front();
                if (if_rdata !== e) begin
                    errors++;
                    $display("FAIL if_rdata: got %h, required %h", if_rdata, e);
                end
            end
        end
        if (dm_done) begin
            checks++;
            if (dq.size() == 0) begin
                errors++;
                $display("FAIL dm_done_unexpected: got dm_rdata=%h, required no done", dm_rdata);
            end else begin
                e = dq.pop_front();
                if (dm_rdata !== e) begin
                    errors++;
                    $display("FAIL dm_rdata: got %h, required %h", dm_rdata, e);
                end
            end
        end
        if (mem_req) begin
            mem_ready = (busy >= mem_lat);
            busy++;
            if (mem_ready) mem_rdata = (mq.size() != 0) ? mq.pop_front() : 32'd0;
            else           mem_rdata = 32'hBAD0BAD0;
        end else begin
            mem_ready = ready_in_idle;
            mem_rdata = 32'h1234_5678;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        if_req = 0; if_addr = 0; dm_req = 0; dm_we = 0; dm_addr = 0; dm_wdata = 0; dm_be = 0;
        mem_ready = 0; mem_rdata = 0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({mem_req, mem_we, if_done, dm_done, err} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got req/we/ifd/dmd/err=%b, required 00000",
                     {mem_req, mem_we, if_done, dm_done, err});
        end
        checks++;
        if (mem_addr !== 32'd0 || mem_wdata !== 32'd0 || mem_be !== 4'd0) begin
            errors++;
            $display("FAIL reset_port: got addr=%h wdata=%h be=%h, required zeros", mem_addr, mem_wdata, mem_be);
        end
        checks++;
        if (if_rdata !== 32'd0 || dm_rdata !== 32'd0) begin
            errors++;
            $display("FAIL reset_rdata: got if=%h dm=%h, required zeros", if_rdata, dm_rdata);
        end
        reset = 1'b1;
        prev_req = 1'b0;
        repeat (3) sb_cycle();
        checks++;
        if (mem_req !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: got mem_req=%b, required 0", mem_req);
        end
    endtask

    task automatic test_fetch_latency();
        mem_lat = 0;
        gq.push_back(mk_g(1'b0, 32'h100, 32'd0, 4'hF, 0));
        mq.push_back(32'hE3A00001);
        iq.push_back(32'hE3A00001);
        if_req = 1; if_addr = 32'h100;
        sb_cycle();
        checks++;
        if (mem_req !== 1'b1 || stall_f !== 1'b1) begin
            errors++;
            $display("FAIL lat_req: got mem_req=%b stall_f=%b one edge after request, required 1 1", mem_req, stall_f);
        end
        sb_cycle();
        checks++;
        if (if_done !== 1'b1 || stall_f !== 1'b0) begin
            errors++;
            $display("FAIL lat_done: got if_done=%b stall_f=%b two edges after request, required 1 0", if_done, stall_f);
        end
        last_if = 32'hE3A00001;
        if_req = 0;
        sb_cycle();
        checks++;
        if (if_done !== 1'b0 || mem_req !== 1'b0) begin
            errors++;
            $display("FAIL lat_pulse: got if_done=%b mem_req=%b, required 0 0", if_done, mem_req);
        end
    endtask

    task automatic test_simultaneous();
        bit stall_bad = 0, stallm_bad = 0, got_if = 0, got_dm = 0;
        mem_lat = 2;
        gq.push_back(mk_g(1'b1, 32'h200, 32'h55, 4'b0001, 1));
        gq.push_back(mk_g(1'b0, 32'h300, 32'd0, 4'hF, 0));
        mq.push_back(32'h0000AAAA); dq.push_back(32'h0000AAAA);
        mq.push_back(32'hE1A00000); iq.push_back(32'hE1A00000);
        if_req = 1; if_addr = 32'h300;
        dm_req = 1; dm_we = 1; dm_addr = 32'h200; dm_wdata = 32'h55; dm_be = 4'b0001;
        for (int i = 0; i < 40 && !got_if; i++) begin
            sb_cycle();
            if (!saw_if && stall_f !== 1'b1) stall_bad = 1;
            if (!got_dm && !saw_dm && stall_m !== 1'b1) stallm_bad = 1;
            if (saw_dm) begin
                if (stall_m !== 1'b0) stallm_bad = 1;
                got_dm = 1;
                dm_req = 0; dm_we = 0;
            end
            if (saw_if) got_if = 1;
        end
        checks++;
        if (!got_if || !got_dm) begin
            errors++;
            $display("FAIL simul_done: got if=%b dm=%b within budget, required 1 1", got_if, got_dm);
        end
        checks++;
        if (stall_bad || stallm_bad) begin
            errors++;
            $display("FAIL simul_stall: got stall_f_bad=%b stall_m_bad=%b, required 0 0", stall_bad, stallm_bad);
        end
        last_if = 32'hE1A00000;
        if_req = 0;
        mem_lat = 0;
        sb_cycle();
    endtask

    task automatic test_starvation();
        bit got_if = 0;
        int dones = 0;
        logic [31:0] a = 32'h1000;
        for (int k = 0; k < 4; k++) begin
            gq.push_back(mk_g(1'b0, 32'h1000 + 32'(k * 4), 32'd0, 4'hF, 0));
            mq.push_back(32'hD0000000 + 32'(k)); dq.push_back(32'hD0000000 + 32'(k));
        end
        gq.push_back(mk_g(1'b0, 32'h400, 32'd0, 4'hF, 0));
        mq.push_back(32'hCAFE0400); iq.push_back(32'hCAFE0400);
        if_req = 1; if_addr = 32'h400;
        dm_req = 1; dm_we = 0; dm_addr = a; dm_be = 4'hF; dm_wdata = 0;
        for (int i = 0; i < 60 && !got_if; i++) begin
            sb_cycle();
            if (saw_dm) begin
                dones++;
                a = a + 32'd4;
                dm_addr = a;
            end
            if (saw_if) begin
                got_if = 1;
                dm_req = 0; if_req = 0;
            end
        end
        checks++;
        if (!got_if || dones != 4) begin
            errors++;
            $display("FAIL starve_order: got fetch_done=%b after %0d data dones, required 1 after 4", got_if, dones);
        end
        last_if = 32'hCAFE0400;
        sb_cycle();
    endtask

    task automatic test_timeout();
        bit hit = 0, early_err = 0;
        int hi = 0;
        mem_lat = 100000;
        gq.push_back(mk_g(1'b0, 32'h2000, 32'd0, 4'hF, 0));
        dq.push_back(32'hDEADBEEF);
        dm_req = 1; dm_we = 0; dm_addr = 32'h2000; dm_be = 4'hF; dm_wdata = 0;
        for (int i = 0; i < 400 && !hit; i++) begin
            sb_cycle();
            if (mem_req) hi++;
            if (saw_err && !saw_dm) early_err = 1;
            if (saw_dm) hit = 1;
        end
        checks++;
        if (!hit || err !== 1'b1 || mem_req !== 1'b0 || early_err) begin
            errors++;
            $display("FAIL timeout_abort: got done=%b err=%b mem_req=%b early_err=%b, required 1 1 0 0",
                     hit, err, mem_req, early_err);
        end
        checks++;
        if (hi != TB_TIMEOUT) begin
            errors++;
            $display("FAIL timeout_len: got mem_req high %0d cycles, required %0d", hi, TB_TIMEOUT);
        end
        dm_req = 0;
        mem_lat = 0;
        sb_cycle();
        checks++;
        if (err !== 1'b0 || dm_done !== 1'b0) begin
            errors++;
            $display("FAIL timeout_pulse: got err=%b dm_done=%b, required 0 0", err, dm_done);
        end
    endtask

    task automatic test_idle_hold();
        int d = 0;
        ready_in_idle = 1;
        for (int i = 0; i < 6; i++) begin
            sb_cycle();
            if (saw_if || saw_dm || mem_req) d++;
        end
        ready_in_idle = 0;
        checks++;
        if (d != 0) begin
            errors++;
            $display("FAIL idle_ready: got %0d cycles with activity, required 0", d);
        end
        checks++;
        if (dm_rdata !== 32'hDEADBEEF || if_rdata !== last_if) begin
            errors++;
            $display("FAIL rdata_hold: got dm=%h if=%h, required %h %h", dm_rdata, if_rdata, 32'hDEADBEEF, last_if);
        end
        sb_cycle();
    endtask

    task automatic test_reset_mid();
        bit seen = 0;
        mem_lat = 100000;
        gq.push_back(mk_g(1'b0, 32'h3000, 32'd0, 4'h3, 0));
        dm_req = 1; dm_we = 0; dm_addr = 32'h3000; dm_be = 4'h3; dm_wdata = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            sb_cycle();
            if (mem_req) seen = 1;
        end
        repeat (3) sb_cycle();
        checks++;
        if (!seen || mem_req !== 1'b1) begin
            errors++;
            $display("FAIL rmid_grant: got mem_req=%b, required 1 before reset", mem_req);
        end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (mem_req !== 1'b0 || dm_done !== 1'b0) begin
            errors++;
            $display("FAIL rmid_async: got mem_req=%b dm_done=%b right after reset, required 0 0", mem_req, dm_done);
        end
        mem_ready = 0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (mem_req !== 1'b0 || dm_done !== 1'b0) begin
            errors++;
            $display("FAIL rmid_held: got mem_req=%b dm_done=%b in reset, required 0 0", mem_req, dm_done);
        end
        reset = 1'b1;
        prev_req = 1'b0;
        mem_lat = 0;
        gq.push_back(mk_g(1'b0, 32'h3000, 32'd0, 4'h3, 0));
        mq.push_back(32'h77770000); dq.push_back(32'h77770000);
        sb_cycle();
        checks++;
        if (mem_req !== 1'b0) begin
            errors++;
            $display("FAIL rmid_first_edge: got mem_req=%b, required 0", mem_req);
        end
        sb_cycle();
        checks++;
        if (mem_req !== 1'b1) begin
            errors++;
            $display("FAIL rmid_regrant: got mem_req=%b on second edge, required 1", mem_req);
        end
        sb_cycle();
        checks++;
        if (dm_done !== 1'b1) begin
            errors++;
            $display("FAIL rmid_done: got dm_done=%b, required 1", dm_done);
        end
        dm_req = 0;
        sb_cycle();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_fetch_latency();
        test_simultaneous();
        test_starvation();
        test_timeout();
        test_idle_hold();
        test_reset_mid();
        checks++;
        if (gq.size() != 0 || iq.size() != 0 || dq.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: got grants=%0d if=%0d dm=%0d left, required 0 0 0",
                     gq.size(), iq.size(), dq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
